simple_dma_controller: RTL and testbench



---
 rtl/simple_dma_controller_pkg.sv | 21 ++
 rtl/simple_dma_controller.sv | 162 ++++++++++++++++
 tb/tb_simple_dma_controller.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_dma_controller_pkg.sv
// Shared constants for the simple DMA controller: FSM state encoding,
// transfer direction and memory byte-enable patterns.
package simple_dma_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_MEM = 3'd1,
        S_RD_CAP = 3'd2,
        S_RD_DEV = 3'd3,
        S_WR_DEV = 3'd4,
        S_WR_MEM = 3'd5,
        S_DONE   = 3'd6
    } dma_state_e;

    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

    localparam logic [1:0] WE_WORD = 2'b11;
    localparam logic [1:0] WE_NONE = 2'b00;

endpackage

// File: rtl/simple_dma_controller.sv
// Block DMA engine moving 16-bit words between a peripheral and data memory.
// Define DMA_BUS_ERROR_EN to abort blocks on mem_resp and report dma_err.
import simple_dma_controller_pkg::*;

module simple_dma_controller #(
    parameter int unsigned ADDR_STEP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic        dma_busy,
    output logic        dma_err,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_en,
    output logic [1:0]  mem_we,
    input  logic [15:0] mem_dout,
    input  logic        mem_ready,
    input  logic        mem_resp
);

    localparam logic [15:0] STEP = 16'(ADDR_STEP);

    dma_state_e  state_q, state_d;
    logic        rqst_q;
    logic [15:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic        dir_q, dir_d;
    logic        err_q, err_d;
    logic        bus_err;
    logic        last_word;

`ifdef DMA_BUS_ERROR_EN
    assign bus_err = mem_resp;
`else
    logic unused_resp;
    assign unused_resp = mem_resp;
    assign bus_err = 1'b0;
`endif

    assign last_word = (cnt_q == 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rqst_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            dir_q   <= DIR_WR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rqst_q  <= dma_rqst;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        dir_d        = dir_q;
        err_d        = err_q;
        mem_en       = 1'b0;
        mem_we       = WE_NONE;
        dma_ack      = 1'b0;
        dma_end_flag = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dma_rqst && !rqst_q) begin
                    addr_d = {dma_start_address[15:1], 1'b0};
                    cnt_d  = dma_num_words;
                    dir_d  = dma_rd_wr;
                    err_d  = 1'b0;
                    if (dma_num_words == 16'd0)
                        state_d = S_DONE;
                    else if (dma_rd_wr == DIR_RD)
                        state_d = S_RD_MEM;
                    else
                        state_d = S_WR_DEV;
                end
            end
            S_RD_MEM: begin
                mem_en = 1'b1;
                if (mem_ready) begin
                    if (bus_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = dma_rqst ? S_RD_CAP : S_DONE;
                    end
                end
            end
            S_RD_CAP: begin
                data_d  = mem_dout;
                state_d = dma_rqst ? S_RD_DEV : S_DONE;
            end
            S_RD_DEV: begin
                if (!dma_rqst) begin
                    state_d = S_DONE;
                end else if (dev_ack) begin
                    dma_ack = 1'b1;
                    addr_d  = addr_q + STEP;
                    cnt_d   = cnt_q - 16'd1;
                    state_d = last_word ? S_DONE : S_RD_MEM;
                end
            end
            S_WR_DEV: begin
                if (!dma_rqst) begin
                    state_d = S_DONE;
                end else if (dev_ack) begin
                    dma_ack = 1'b1;
                    data_d  = dev_out;
                    state_d = S_WR_MEM;
                end
            end
            S_WR_MEM: begin
                mem_en = 1'b1;
                mem_we = WE_WORD;
                if (mem_ready) begin
                    if (bus_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + STEP;
                        cnt_d   = cnt_q - 16'd1;
                        // a dropped request ends the block once this write lands
                        state_d = (last_word || !dma_rqst) ? S_DONE : S_WR_DEV;
                    end
                end
            end
            S_DONE: begin
                dma_end_flag = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dma_busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign dev_in   = (dir_q == DIR_RD) ? data_q : 16'd0;
    assign mem_addr = addr_q[15:1];
    assign mem_din  = data_q;
    assign dma_err  = err_q;

endmodule

// File: tb/tb_simple_dma_controller.sv
// Scoreboard bench for simple_dma_controller: a memory/device model with
// random stalls feeds expected transactions to a negedge monitor.
module tb_simple_dma_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dma_rqst = 1'b0;
    logic        dma_rd_wr = 1'b0;
    logic [15:0] dma_start_address = '0;
    logic [15:0] dma_num_words = '0;
    logic        dev_ack = 1'b0;
    logic [15:0] dev_out;
    logic [15:0] dev_in;
    logic        dma_ack, dma_end_flag, dma_busy, dma_err;
    logic [14:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_en;
    logic [1:0]  mem_we;
    logic [15:0] mem_dout = '0;
    logic        mem_ready = 1'b0;
    logic        mem_resp = 1'b0;

    always #5 clk = ~clk;

    simple_dma_controller #(.ADDR_STEP(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
        .dma_start_address(dma_start_address),
        .dma_num_words(dma_num_words),
        .dev_ack(dev_ack), .dev_out(dev_out), .dev_in(dev_in),
        .dma_ack(dma_ack), .dma_end_flag(dma_end_flag),
        .dma_busy(dma_busy), .dma_err(dma_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en),
        .mem_we(mem_we), .mem_dout(mem_dout),
        .mem_ready(mem_ready), .mem_resp(mem_resp)
    );

    typedef struct {
        logic [14:0] a;
        logic [1:0]  we;
        logic [15:0] d;
    } mx_t;

    logic [15:0] mem [0:32767];
    logic [15:0] dev_words [0:255];
    logic [7:0]  dev_idx = '0;
    int          wr_acc = 0;
    int          ack_cnt = 0;
    int          rdy_pct = 100;
    int          ack_pct = 100;
    int          mem_stall = 0;
    int          dev_stall = 0;
    bit          cur_dir = 1'b0;
    int          tests = 0;
    int          fails = 0;
    mx_t         exp_mem[$];
    logic [15:0] exp_dev[$];
    bit          hold_v = 1'b0;
    mx_t         hold_x;

    assign dev_out = dev_words[dev_idx];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory and device responders
    always @(posedge clk) begin
        if (mem_en && mem_ready) begin
            if (mem_we == 2'b11) begin
                mem[mem_addr] <= mem_din;
                wr_acc <= wr_acc + 1;
            end else begin
                mem_dout <= mem[mem_addr];
            end
        end
        if (dma_ack) dev_idx <= dev_idx + 8'd1;
    end

    // handshake drivers plus scoreboard monitor
    always @(negedge clk) begin
        if (mem_en && mem_stall > 0) begin
            mem_ready = 1'b0;
            mem_stall--;
        end else begin
            mem_ready = ($urandom_range(99) < rdy_pct);
        end
        if (dma_busy && !mem_en && dev_stall > 0) begin
            dev_ack = 1'b0;
            dev_stall--;
        end else begin
            dev_ack = ($urandom_range(99) < ack_pct);
        end
        #1;
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("mem_hold_en", mem_en, 1);
                chk("mem_hold_addr", mem_addr, hold_x.a);
                chk("mem_hold_we", mem_we, hold_x.we);
                chk("mem_hold_din", mem_din, hold_x.d);
            end
            hold_v = mem_en && !mem_ready;
            hold_x = '{mem_addr, mem_we, mem_din};
            if (mem_en && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_unexpected: got access addr %0h, none expected", mem_addr);
                end else begin
                    mx_t x;
                    x = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, x.a);
                    chk("mem_we", mem_we, x.we);
                    if (x.we == 2'b11) chk("mem_din", mem_din, x.d);
                end
            end
            if (dma_ack) begin
                ack_cnt++;
                if (cur_dir) begin
                    if (exp_dev.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL ack_unexpected: got dev_in %0h, none expected", dev_in);
                    end else begin
                        chk("dev_in", dev_in, exp_dev.pop_front());
                    end
                end else begin
                    chk("dev_in_wr_zero", dev_in, 0);
                end
            end
            if (dma_end_flag) chk("busy_at_end", dma_busy, 0);
        end
    end

    task automatic push_exp(input logic [15:0] start, input int words,
                            input bit dir, input logic [7:0] b);
        logic [15:0] a;
        for (int i = 0; i < words; i++) begin
            a = {start[15:1], 1'b0} + 16'(2 * i);
            if (dir) begin
                exp_mem.push_back('{a[15:1], 2'b00, 16'h0});
                exp_dev.push_back(mem[a[15:1]]);
            end else begin
                exp_mem.push_back('{a[15:1], 2'b11, dev_words[b + 8'(i)]});
            end
        end
    endtask

    task automatic run_block(input logic [15:0] start, input int n, input bit dir,
                             input int lat, input bit exact, input int abort_at);
        int          words;
        logic [7:0]  b;
        int          a0;
        int          w0;
        int          cyc;
        bit          seen;
        logic [15:0] a;
        words = (abort_at >= 0) ? abort_at : n;
        b = dev_idx;
        a0 = ack_cnt;
        w0 = wr_acc;
        cyc = 0;
        seen = 1'b0;
        cur_dir = dir;
        push_exp(start, words, dir, b);
        dma_start_address = start;
        dma_num_words = 16'(n);
        dma_rd_wr = dir;
        dma_rqst = 1'b1;
        while (cyc < 400 && !seen) begin
            @(negedge clk);
            #2;
            cyc++;
            if (abort_at >= 0 && dma_rqst && mem_en && mem_we == 2'b11
                && wr_acc - w0 == abort_at - 1)
                dma_rqst = 1'b0;
            seen = dma_end_flag;
        end
        chk("end_flag_seen", seen, 1);
        if (seen && lat > 0) begin
            if (exact) chk("latency", cyc, lat);
            else chk("latency_max", cyc <= lat, 1);
        end
        chk("mem_queue_drained", exp_mem.size(), 0);
        chk("dev_queue_drained", exp_dev.size(), 0);
        chk("ack_count", ack_cnt - a0, words);
        chk("dma_err", dma_err, 0);
        if (!dir) begin
            for (int i = 0; i < words; i++) begin
                a = {start[15:1], 1'b0} + 16'(2 * i);
                chk("mem_content", mem[a[15:1]], dev_words[b + 8'(i)]);
            end
        end
        exp_mem.delete();
        exp_dev.delete();
        if (abort_at < 0) begin
            repeat (3) begin
                @(negedge clk);
                #2;
                chk("held_rqst_no_restart", dma_busy, 0);
            end
        end
        dma_rqst = 1'b0;
        @(negedge clk);
        #2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) dev_words[i] = 16'($urandom);

        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", dma_busy, 0);
        chk("rst_end", dma_end_flag, 0);
        chk("rst_ack", dma_ack, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_dev_in", dev_in, 0);
        chk("rst_err", dma_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        #2;

        mem[15'h100] = 16'hA1A1;
        mem[15'h101] = 16'hB2B2;
        mem[15'h102] = 16'hC3C3;
        run_block(16'h0200, 3, 1'b1, 10, 1'b1, -1);

        b = dev_idx;
        dev_words[b] = 16'h0005;
        dev_words[b + 8'd1] = 16'h0006;
        run_block(16'h0300, 2, 1'b0, 5, 1'b1, -1);
        chk("wr_word0", mem[15'h180], 16'h0005);
        chk("wr_word1", mem[15'h181], 16'h0006);

        run_block(16'h1234, 0, 1'b1, 2, 1'b0, -1);

        run_block(16'hFFFE, 2, 1'b1, 7, 1'b1, -1);

        mem_stall = 3;
        dev_stall = 2;
        run_block(16'h0400, 1, 1'b0, 8, 1'b1, -1);

        mem_stall = 3;
        run_block(16'h0410, 1, 1'b1, 7, 1'b1, -1);

        run_block(16'h0500, 4, 1'b0, 0, 1'b0, 2);

        cur_dir = 1'b1;
        push_exp(16'h0600, 5, 1'b1, dev_idx);
        dma_start_address = 16'h0600;
        dma_num_words = 16'd5;
        dma_rd_wr = 1'b1;
        dma_rqst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #2;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", dma_busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_dev_in", dev_in, 0);
        chk("midrst_ack", dma_ack, 0);
        chk("midrst_end", dma_end_flag, 0);
        dma_rqst = 1'b0;
        @(negedge clk);
        exp_mem.delete();
        exp_dev.delete();
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        #2;

        for (int k = 0; k < 12; k++) begin
            rdy_pct = $urandom_range(40, 100);
            ack_pct = $urandom_range(40, 100);
            run_block(16'($urandom), $urandom_range(0, 6), 1'($urandom), 0, 1'b0, -1);
        end
        rdy_pct = 100;
        ack_pct = 100;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
